// File: rtl/wpg_pkg.sv
// Shared constants, state encoding and binomial table for the weight pattern generator.
package wpg_pkg;

  localparam int WIDTH = 8;
  localparam int WGT_W = 4;
  localparam int IDX_W = 7;

  // Largest legal weight; anything above it is rejected at start.
  localparam logic [WGT_W-1:0] MAX_WGT = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of 8-bit patterns holding exactly k ones, C(8,k).
  localparam logic [IDX_W-1:0] BINOM [0:8] = '{
    7'd1, 7'd8, 7'd28, 7'd56, 7'd70, 7'd56, 7'd28, 7'd8, 7'd1
  };

  // Ordinal of the final pattern for weight k (weights above 8 never reach here).
  function automatic logic [IDX_W-1:0] last_index(input logic [WGT_W-1:0] k);
    logic [IDX_W-1:0] n;
    case (k)
      4'd0:    n = BINOM[0];
      4'd1:    n = BINOM[1];
      4'd2:    n = BINOM[2];
      4'd3:    n = BINOM[3];
      4'd4:    n = BINOM[4];
      4'd5:    n = BINOM[5];
      4'd6:    n = BINOM[6];
      4'd7:    n = BINOM[7];
      default: n = BINOM[8];
    endcase
    return n - 7'd1;
  endfunction

endpackage

// File: rtl/weight_pattern_gen_if.sv
// Control and pattern stream bundle of the weight pattern generator.
// Handshake: a pattern transfers on a rising clock edge where valid && ready;
// once valid is high, pattern/index/last hold steady and valid stays high
// until that transfer happens. ready has no effect while valid is low.
interface weight_pattern_gen_if;
  import wpg_pkg::*;

  logic             start;
  logic [WGT_W-1:0] weight;
  logic             ready;
  logic [WIDTH-1:0] pattern;
  logic             valid;
  logic             last;
  logic [IDX_W-1:0] index;
  logic             busy;
  logic             done;
  logic             err;

  // Generator side.
  modport master (
    input  start, weight, ready,
    output pattern, valid, last, index, busy, done, err
  );

  // Requester / consumer side.
  modport slave (
    output start, weight, ready,
    input  pattern, valid, last, index, busy, done, err
  );

endinterface

// File: rtl/popcount8.sv
// Combinational count of ones in an 8-bit word (unregistered balancer datapath).
module popcount8 (
  input  logic [7:0] i_data,
  output logic [3:0] o_count
);

  // Sum the eight bits.
  always_comb begin
    o_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + {3'b000, i_data[i]};
    end
  end

endmodule

// File: rtl/weight_pattern_gen.sv
// Emits every 8-bit pattern with exactly k ones, ascending, over a valid/ready stream.
// Candidates 0..255 are walked one per SCAN cycle; a run ends when the pattern
// ordinal reaches C(8,k)-1, so the candidate counter never has to wrap.
module weight_pattern_gen
  import wpg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  weight_pattern_gen_if.master  bus,
  output state_t                o_dbg_state
);

  state_t           r_state;
  logic [WGT_W-1:0] r_w;
  logic [WIDTH-1:0] r_cand;
  logic             r_prime;
  logic [WIDTH-1:0] r_pattern;
  logic             r_valid;
  logic             r_last;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WGT_W-1:0] w_cnt;
  logic             w_hit;

  popcount8 u_popcount (
    .i_data  (r_cand),
    .o_count (w_cnt)
  );

  assign w_hit = (w_cnt == r_w);

  // Control FSM; every output is a register updated here.
  // The first SCAN cycle after a start is a priming cycle that neither tests
  // nor advances the candidate, so candidate c is tested at start edge + 2 + c.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_w       <= '0;
      r_cand    <= '0;
      r_prime   <= 1'b0;
      r_pattern <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.weight > MAX_WGT) begin
              r_err <= 1'b1;
            end else begin
              r_w     <= bus.weight;
              r_cand  <= '0;
              r_idx   <= '0;
              r_prime <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (r_prime) begin
            r_prime <= 1'b0;
          end else begin
            r_cand <= r_cand + 8'd1;
            if (w_hit) begin
              r_pattern <= r_cand;
              r_valid   <= 1'b1;
              r_last    <= (r_idx == last_index(r_w));
              r_state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.ready) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + 7'd1;
              r_state <= SCAN;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pattern  = r_pattern;
  assign bus.valid    = r_valid;
  assign bus.last     = r_last;
  assign bus.index    = r_idx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/weight_pattern_gen.md
Name: weight_pattern_gen

Overview:
- Inverse of the byte population-count block: given a target weight k (0..8), emits every 8-bit pattern containing exactly k ones, in ascending numeric order.
- Patterns are delivered over a valid/ready stream.
- Feeds the popcount block and downstream balancers with exhaustive stimulus, and serves as an on-chip constrained-pattern source for BIST.
- Internally scans candidates 0..255 through a registered-free popcount sub-module.

Parameters:
- WIDTH, 8, pattern width in bits; only 8 is supported in this revision.
- WGT_W, 4, weight/count field width, equal to $clog2(WIDTH+1).
- IDX_W, 7, pattern-ordinal width; must hold max C(8,k) = 70.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  request generation; sampled only in IDLE
- weight  input  4  target number of ones; latched on accepted start
- ready  input  1  consumer can take pattern this cycle
- pattern  output  8  current pattern; stable while valid && !ready
- valid  output  1  pattern is valid
- last  output  1  qualifies valid; final pattern for this weight
- index  output  7  0-based ordinal of the current pattern
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last pattern is accepted
- err  output  1  one-cycle pulse when start is accepted with weight > 8

Behaviour:
- Reset (reset==0, async): state=IDLE; pattern=0, valid=0, last=0, index=0, busy=0, done=0, err=0; candidate=0; weight register=0. All outputs are registered.
- States: IDLE, SCAN, HOLD, DONE.
- IDLE:
  - start==1 and weight<=8: latch weight to w, candidate<=0, index<=0, go to SCAN.
  - start==1 and weight>8: err=1 for one cycle, stay in IDLE, never assert valid.
- SCAN (one candidate per cycle):
  - If popcount(candidate)==w: pattern<=candidate, valid<=1, last<=(index==BINOM[w]-1), go to HOLD.
  - In every SCAN cycle, candidate<=candidate+1 (8-bit).
- HOLD:
  - valid==1; pattern, index and last are held stable until ready==1.
  - On valid&&ready with last==1: valid<=0, go to DONE.
  - On valid&&ready with last==0: valid<=0, index<=index+1, go to SCAN.
  - valid is never dropped without a handshake.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays high through DONE.
- Termination is decided by the binomial table, not by candidate wrap. The candidate counter never needs to wrap, because the last pattern for weight k is found at candidate ((2^k-1)<<(8-k)) <= 255.
- Latency: start accepted at edge t → first valid at edge t+1+2^k. Examples: k=0 at t+2; k=8 at t+257.
- Throughput: at most one pattern per 2 cycles (HOLD→SCAN). No pipelining of the scan.
- start while busy is ignored with no side effects. ready while valid==0 is ignored.
- Simultaneous start and final handshake: start is ignored, because the block is in HOLD, not IDLE.
- Reset mid-operation: immediate abort to reset values. No done pulse, no partial resume.

Decomposition:
- Package wpg_pkg:
  - WIDTH, WGT_W, IDX_W constants.
  - State enum typedef {IDLE, SCAN, HOLD, DONE}.
  - BINOM[0..8] constant table = 1,8,28,56,70,56,28,8,1.
- Sub-module popcount8: combinational 8→4-bit ones counter with the same function as the existing balancer datapath, minus the register. Instantiated once on the candidate.

Test Plan:
- weight=3, ready held high → 56 patterns, first 0x07, second 0x0B, final 0xE0 with last=1 and index=55. Every pattern has popcount 3 and is strictly increasing. done pulses once, busy falls the cycle after done.
- weight=0 → single pattern 0x00 at start-edge+2, last=1, index=0, then done. weight=8 → single 0xFF at start-edge+257, last=1.
- weight=9 → err pulse of exactly 1 cycle. valid, busy and done stay 0. A subsequent start with weight=1 yields 0x01, 0x02, …, 0x80 (8 patterns).
- Backpressure on weight=2: drop ready for 5 cycles while valid → pattern/index/last are unchanged and valid stays 1. Total accepted count is still 28.
- Pulse start with weight=5 mid-run of weight=4 → ignored; the run completes with 70 patterns of weight 4.
- Assert reset low during HOLD of weight=4 → all outputs 0 asynchronously, no done pulse. After release, a fresh start with weight=1 produces 0x01 first.
